// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature A/B decoder that turns encoder phases into one-cycle step pulses
// Ports: clk; reset_n async active-low; quad_a/quad_b async encoder phases; enable gates step pulses;
// increment/decrement one-cycle step pulses; step_err one-cycle illegal-transition pulse;
// dir last accepted direction (1 = forward); locked high once the initial phase is captured.
// Macro QSD_ERR_CNT_EN adds err_count[7:0], a saturating count of step_err pulses.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       enable,
  output logic       increment,
  output logic       decrement,
  output logic       step_err,
  output logic       dir,
`ifdef QSD_ERR_CNT_EN
  output logic [7:0] err_count,
`endif
  output logic       locked
);
  typedef enum logic {INIT, TRACK} state_t;
  localparam logic [3:0] FLIM = 4'(FILTER_LEN - 1);
  localparam logic [4:0] ILIM = 5'(SYNC_STAGES + FILTER_LEN - 1);
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic [1:0] raw, lvl, hit, filt_q, filt_d, prev_q, prev_d, step;
  logic [4:0] init_q, init_d;
  state_t state_q, state_d;
  logic inc_q, inc_d, dec_q, dec_d, err_q, err_d, dir_q, dir_d;
  // Gray phase to position along the forward order 00,01,11,10
  function automatic logic [1:0] pos(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction
  assign raw = {quad_b, quad_a};
  assign step = pos(filt_q) - pos(prev_q);
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
      lvl[i] = sync_q[i][SYNC_STAGES-1];
      hit[i] = lvl[i] != filt_q[i] && fcnt_q[i] == FLIM;
      fcnt_d[i] = (lvl[i] == filt_q[i] || hit[i]) ? 4'd0 : fcnt_q[i] + 4'd1;
      filt_d[i] = hit[i] ? lvl[i] : filt_q[i];
    end
  end
  // INIT waits for the synchroniser to fill and the filters to settle before capturing the phase
  always_comb begin
    state_d = state_q;
    prev_d = prev_q;
    init_d = init_q;
    inc_d = 1'b0;
    dec_d = 1'b0;
    err_d = 1'b0;
    dir_d = dir_q;
    if (state_q == INIT) begin
      init_d = init_q == ILIM ? init_q : init_q + 5'd1;
      if (init_q == ILIM && filt_d == lvl) begin
        state_d = TRACK;
        prev_d = filt_d;
      end
    end else if (filt_q != prev_q) begin
      prev_d = filt_q;
      inc_d = step == 2'd1 && enable;
      dec_d = step == 2'd3 && enable;
      err_d = step == 2'd2;
      dir_d = step == 2'd1 ? 1'b1 : step == 2'd3 ? 1'b0 : dir_q;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      fcnt_q <= '0;
      filt_q <= '0;
      prev_q <= '0;
      init_q <= '0;
      state_q <= INIT;
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      err_q <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
      prev_q <= prev_d;
      init_q <= init_d;
      state_q <= state_d;
      inc_q <= inc_d;
      dec_q <= dec_d;
      err_q <= err_d;
      dir_q <= dir_d;
    end
  end
  assign increment = inc_q;
  assign decrement = dec_q;
  assign step_err = err_q;
  assign dir = dir_q;
  assign locked = state_q == TRACK;
`ifdef QSD_ERR_CNT_EN
  logic [7:0] err_count_q, err_count_d;
  assign err_count_d = err_d && err_count_q != 8'hff ? err_count_q + 8'd1 : err_count_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_count_q <= '0;
    else err_count_q <= err_count_d;
  end
  assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: randomized self-checking bench for quad_step_decoder
module tb_quad_step_decoder;
  localparam int SS = 2, FL = 3, LAT = SS + FL + 1, DEPTH = 8192;
  logic clk = 1'b0;
  logic reset_n, quad_a, quad_b, enable;
  logic increment, decrement, step_err, dir, locked;
`ifdef QSD_ERR_CNT_EN
  logic [7:0] err_count;
`endif
  int checks = 0, errors = 0, cyc = 0, m_errs = 0;
  bit [2:0] exp_ev [DEPTH];
  logic [1:0] fwd_tbl [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
  logic [1:0] rev_tbl [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
  logic [1:0] m_phase;
  bit m_dir;
  quad_step_decoder #(.SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .quad_a(quad_a),
    .quad_b(quad_b),
    .enable(enable),
    .increment(increment),
    .decrement(decrement),
    .step_err(step_err),
    .dir(dir),
`ifdef QSD_ERR_CNT_EN
    .err_count(err_count),
`endif
    .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  // Reference: classify the new phase against the forward/reverse successor tables and
  // schedule the expected {increment, decrement, step_err} LAT edges after the drive.
  task automatic drive_phase(input logic [1:0] p, input bit en);
    bit [2:0] ev;
    ev = 3'b000;
    if (p == fwd_tbl[m_phase]) begin
      ev = {en, 2'b00};
      m_dir = 1'b1;
    end else if (p == rev_tbl[m_phase]) begin
      ev = {1'b0, en, 1'b0};
      m_dir = 1'b0;
    end else if (p != m_phase) begin
      ev = 3'b001;
      if (m_errs < 255) m_errs++;
    end
    if (cyc + LAT < DEPTH) exp_ev[cyc + LAT] = ev;
    {quad_b, quad_a} = p;
    enable = en;
    m_phase = p;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    quad_a = 1'b1;
    quad_b = 1'b1;
    enable = 1'b1;
    repeat (3) tick();
    checks++;
    if ({increment, decrement, step_err, dir, locked} !== 5'b0)
      begin errors++; $display("FAIL reset_outputs got=%b exp=00000", {increment, decrement, step_err, dir, locked}); end
    reset_n = 1'b1;
    m_phase = 2'b11;
    m_dir = 1'b0;
    m_errs = 0;
    for (int k = 1; k <= SS + FL + 4; k++) begin
      tick();
      checks++;
      if (locked !== 1'(k >= SS + FL))
        begin errors++; $display("FAIL lock_time edge=%0d got=%b exp=%b", k, locked, 1'(k >= SS + FL)); end
      checks++;
      if ({increment, decrement, step_err} !== 3'b000)
        begin errors++; $display("FAIL reset_pulse edge=%0d got=%b exp=000", k, {increment, decrement, step_err}); end
    end
`ifdef QSD_ERR_CNT_EN
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d exp=0", err_count); end
`endif
  endtask
  task automatic test_forward();
    int ni = 0, nd = 0;
    for (int s = 0; s < 8; s++) begin
      drive_phase(fwd_tbl[m_phase], 1'b1);
      for (int k = 0; k < 10; k++) begin
        tick();
        checks++;
        if ({increment, decrement, step_err} !== exp_ev[cyc])
          begin errors++; $display("FAIL fwd_pulse cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
        if (increment === 1'b1) ni++;
        if (decrement === 1'b1) nd++;
      end
    end
    checks++;
    if (ni != 8 || nd != 0) begin errors++; $display("FAIL fwd_count got inc=%0d dec=%0d exp inc=8 dec=0", ni, nd); end
    checks++;
    if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir got=%b exp=1", dir); end
  endtask
  task automatic test_reverse();
    int ni = 0, nd = 0;
    for (int s = 0; s < 7; s++) begin
      drive_phase(s < 5 ? rev_tbl[m_phase] : fwd_tbl[m_phase], 1'b1);
      for (int k = 0; k < 10; k++) begin
        tick();
        checks++;
        if ({increment, decrement, step_err} !== exp_ev[cyc])
          begin errors++; $display("FAIL rev_pulse cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
        checks++;
        if (increment === 1'b1 && decrement === 1'b1)
          begin errors++; $display("FAIL overlap cyc=%0d got=11 exp=not both", cyc); end
        if (increment === 1'b1) ni++;
        if (decrement === 1'b1) nd++;
      end
      if (s == 4) begin
        checks++;
        if (dir !== 1'b0) begin errors++; $display("FAIL rev_dir got=%b exp=0", dir); end
        checks++;
        if (nd != 5 || ni != 0) begin errors++; $display("FAIL rev_count got inc=%0d dec=%0d exp inc=0 dec=5", ni, nd); end
      end
    end
    checks++;
    if (ni != 2 || nd != 5) begin errors++; $display("FAIL revfwd_count got inc=%0d dec=%0d exp inc=2 dec=5", ni, nd); end
    checks++;
    if (dir !== 1'b1) begin errors++; $display("FAIL revfwd_dir got=%b exp=1", dir); end
  endtask
  task automatic test_glitch();
    quad_a = ~quad_a;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 1) quad_a = ~quad_a;
      checks++;
      if ({increment, decrement, step_err} !== exp_ev[cyc])
        begin errors++; $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
    end
    drive_phase(fwd_tbl[m_phase], 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({increment, decrement, step_err} !== exp_ev[cyc])
        begin errors++; $display("FAIL post_glitch cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
    end
  endtask
  task automatic test_error();
    int ne = 0, ns = 0;
    for (int e = 0; e < 300; e++) begin
      drive_phase(m_phase ^ 2'b11, 1'b1);
      for (int k = 0; k < 7; k++) begin
        tick();
        checks++;
        if ({increment, decrement, step_err} !== exp_ev[cyc])
          begin errors++; $display("FAIL err_pulse cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
        if (step_err === 1'b1) ne++;
        if (increment === 1'b1 || decrement === 1'b1) ns++;
      end
`ifdef QSD_ERR_CNT_EN
      if (e == 0) begin
        checks++;
        if (err_count !== 8'(m_errs)) begin errors++; $display("FAIL errcnt_first got=%0d exp=%0d", err_count, m_errs); end
      end
`endif
    end
    checks++;
    if (ne != 300 || ns != 0) begin errors++; $display("FAIL err_count_pulses got err=%0d steps=%0d exp err=300 steps=0", ne, ns); end
    checks++;
    if (dir !== m_dir) begin errors++; $display("FAIL err_dir got=%b exp=%b", dir, m_dir); end
`ifdef QSD_ERR_CNT_EN
    checks++;
    if (err_count !== 8'd255) begin errors++; $display("FAIL errcnt_sat got=%0d exp=255", err_count); end
`endif
  endtask
  task automatic test_enable();
    int ni = 0;
    for (int s = 0; s < 4; s++) begin
      drive_phase(fwd_tbl[m_phase], s == 3);
      for (int k = 0; k < 10; k++) begin
        tick();
        checks++;
        if ({increment, decrement, step_err} !== exp_ev[cyc])
          begin errors++; $display("FAIL enable_pulse cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
        if (increment === 1'b1) ni++;
      end
    end
    checks++;
    if (ni != 1) begin errors++; $display("FAIL enable_count got inc=%0d exp inc=1", ni); end
    checks++;
    if (dir !== 1'b1) begin errors++; $display("FAIL enable_dir got=%b exp=1", dir); end
  endtask
  task automatic test_random();
    int r, hold;
    logic [1:0] p;
    for (int s = 0; s < 60; s++) begin
      r = $urandom_range(0, 2);
      p = r == 0 ? fwd_tbl[m_phase] : r == 1 ? rev_tbl[m_phase] : m_phase ^ 2'b11;
      drive_phase(p, $urandom_range(0, 3) != 0);
      hold = $urandom_range(7, 12);
      for (int k = 0; k < hold; k++) begin
        tick();
        checks++;
        if ({increment, decrement, step_err} !== exp_ev[cyc])
          begin errors++; $display("FAIL rand_pulse cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
      end
      checks++;
      if (dir !== m_dir) begin errors++; $display("FAIL rand_dir step=%0d got=%b exp=%b", s, dir, m_dir); end
    end
  endtask
  task automatic test_reset_mid();
    drive_phase(fwd_tbl[m_phase], 1'b1);
    for (int k = 0; k < LAT; k++) begin
      tick();
      checks++;
      if ({increment, decrement, step_err} !== exp_ev[cyc])
        begin errors++; $display("FAIL mid_pulse cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({increment, decrement, step_err, dir, locked} !== 5'b0)
      begin errors++; $display("FAIL mid_reset got=%b exp=00000", {increment, decrement, step_err, dir, locked}); end
`ifdef QSD_ERR_CNT_EN
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL mid_errcnt got=%0d exp=0", err_count); end
`endif
    m_dir = 1'b0;
    m_errs = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 1; k <= SS + FL + 10; k++) begin
      tick();
      checks++;
      if (locked !== 1'(k >= SS + FL))
        begin errors++; $display("FAIL relock_time edge=%0d got=%b exp=%b", k, locked, 1'(k >= SS + FL)); end
      checks++;
      if ({increment, decrement, step_err} !== 3'b000)
        begin errors++; $display("FAIL relock_pulse edge=%0d got=%b exp=000", k, {increment, decrement, step_err}); end
    end
    drive_phase(fwd_tbl[m_phase], 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({increment, decrement, step_err} !== exp_ev[cyc])
        begin errors++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc, {increment, decrement, step_err}, exp_ev[cyc]); end
    end
    checks++;
    if (dir !== 1'b1) begin errors++; $display("FAIL post_reset_dir got=%b exp=1", dir); end
  endtask
  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_error();
    test_enable();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Quadrature (A/B) decoder that turns an encoder's two-phase signals into single-cycle increment/decrement step pulses.
- Its outputs drive the increment/decrement inputs of the team's up/down counter; it is the producing end of that step interface.
- Synchronises and glitch-filters asynchronous encoder inputs, tracks Gray-code phase with a small FSM, and flags illegal transitions.

Parameters:
- SYNC_STAGES, 2, synchroniser flops per input channel; legal range 2..4.
- FILTER_LEN, 3, consecutive clk edges a synchronised level must differ from the filtered level before it is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- quad_a  input  1  encoder phase A; asynchronous to clk.
- quad_b  input  1  encoder phase B; asynchronous to clk.
- enable  input  1  when 0, step pulses are suppressed; phase tracking continues.
- increment  output  1  one-cycle pulse per forward step.
- decrement  output  1  one-cycle pulse per reverse step.
- step_err  output  1  one-cycle pulse on an illegal phase transition (both bits changed).
- dir  output  1  last accepted direction; 1 = forward, 0 = reverse.
- locked  output  1  1 once the initial phase has been captured (FSM in TRACK).

Behaviour:
- Reset (reset_n=0, immediate and asynchronous):
  - All synchroniser flops, filter counters and filtered levels clear to 0.
  - FSM enters INIT.
  - increment, decrement, step_err, dir and locked are all 0.
- Synchroniser: each channel passes through SYNC_STAGES flops; no logic between the stages.
- Filter (per channel, independent):
  - The counter increments while sync != filt and clears whenever sync == filt.
  - filt takes the sync value on the edge where the counter would reach FILTER_LEN; the counter then clears.
  - Pulses shorter than FILTER_LEN cycles after synchronisation are discarded.
- Phase order, forward: 00 -> 01 -> 11 -> 10 -> 00 (phase = {filt_b, filt_a}). Reverse is the opposite order.
- FSM states: INIT and TRACK.
  - INIT exits after a filtered phase has been stable for FILTER_LEN cycles following reset release: that phase is loaded into prev_phase, locked goes to 1, no pulse and no error are produced.
  - TRACK, every edge where filtered phase != prev_phase:
    - One-step forward: increment=1 on the next edge if enable=1; dir<=1.
    - One-step reverse: decrement=1 on the next edge if enable=1; dir<=0.
    - Two-step (both bits changed): step_err=1 on the next edge regardless of enable; no step pulse; dir is unchanged.
    - In all three cases prev_phase <= the new phase.
- increment and decrement are never high together. Each is high for exactly one cycle per accepted step.
- Latency: a raw level change that is stable from edge N produces its pulse high after edge N+SYNC_STAGES+FILTER_LEN+1 (defaults: 6 edges).
- enable=0: phase, dir and step_err still update, so no step is "replayed" when enable later returns to 1.
- Maximum step rate: one step per FILTER_LEN+1 cycles. Faster input is undefined, but must never produce simultaneous increment and decrement.
- Reset asserted mid-operation: outputs clear immediately; INIT is re-entered after release; no pulse is generated from pre-reset history.

Optional Feature:
- Macro: QSD_ERR_CNT_EN.
- Defined:
  - Adds output err_count [7:0]: saturating count of step_err pulses; holds at 255.
  - Cleared only by reset_n.
  - Increments on the same edge step_err is asserted.
- Undefined: the err_count port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with A=1,B=1 held: locked=1 after exactly SYNC_STAGES+FILTER_LEN edges; no increment, decrement or step_err at any time.
- Forward sweep of 8 steps (00,01,11,10,00,...), 10 cycles per step, enable=1: exactly 8 increment pulses, 0 decrement; each pulse 6 edges after its input change; dir=1.
- Reverse sweep of 5 steps, then 2 forward: 5 decrement pulses then 2 increment pulses; dir goes 0 then 1; increment and decrement never overlap.
- 2-cycle glitch on A (0->1->0) with FILTER_LEN=3: no pulse, no error; filtered phase unchanged.
- A and B toggled on the same cycle from phase 00 to 11: one step_err pulse, no step pulse; with QSD_ERR_CNT_EN, err_count=1. 300 such events: err_count=255.
- enable=0 during 3 forward steps, then enable=1 and 1 forward step: exactly 1 increment pulse. Reset asserted mid-sweep: all outputs 0 within the same cycle.
